// File: rtl/axi_mm2s_dma_if.sv
// Bus bundle for axi_mm2s_dma: command/status, AXI4 AR and R channels, AXI4-Stream output.
// Latency: none, this file only carries wires.
// Backpressure: valid/ready on every channel; cmd_ready gates command acceptance.
//
// Modports:
//   master - the DMA side: drives cmd_ready/status, AR, RREADY and the stream.
//   slave  - the environment side: memory slave, command source and stream sink.
interface axi_mm2s_dma_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 20
) ();
    // command and status
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              busy;
    logic              done;
    logic              err;
    // AXI4 read address
    logic              ARVALID;
    logic              ARREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    // AXI4 read data
    logic              RVALID;
    logic              RREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    // AXI4-Stream output
    logic              TVALID;
    logic              TREADY;
    logic [DATA_W-1:0] TDATA;
    logic              TLAST;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        output cmd_ready, busy, done, err,
        output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST,
        input  ARREADY,
        input  RVALID, RDATA, RRESP, RLAST,
        output RREADY,
        output TVALID, TDATA, TLAST,
        input  TREADY
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        input  cmd_ready, busy, done, err,
        input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST,
        output ARREADY,
        output RVALID, RDATA, RRESP, RLAST,
        input  RREADY,
        input  TVALID, TDATA, TLAST,
        output TREADY
    );
endinterface

// File: rtl/axi_mm2s_dma.sv
// Memory-to-stream DMA: (addr, len) command -> AXI4 read bursts -> FIFO -> AXI4-Stream with TLAST.
// Latency: AR one cycle after entering ADDR; an R beat reaches TVALID one clock after its acceptance.
// Backpressure: AR is held back until the FIFO can absorb the whole burst; RREADY is then held high.
//
// Ports: ACLK/ARESET (async active-high), bus (axi_mm2s_dma_if.master) carrying the command/status
// handshake, the AXI4 AR/R channels and the AXI4-Stream output.
// Optional feature: define DMA_4K_SPLIT_EN to keep every burst inside one 4 KB address page.
module axi_mm2s_dma #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 20,
    parameter int MAX_BURST  = 256,
    parameter int FIFO_DEPTH = 512
) (
    input logic            ACLK,
    input logic            ARESET,
    axi_mm2s_dma_if.master bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        r_state;
    logic              r_rdy_en;    // keeps cmd_ready low until the first clock after reset
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_rem;
    logic [8:0]        r_blen;
    logic [8:0]        r_beat;
    logic [LEN_W-1:0]  r_send;
    logic              r_err;
    logic              r_done;
    logic              r_arvalid;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;       // beats held in r_mem, not counting the output register
    logic              r_tvalid;
    logic [DATA_W-1:0] r_tdata;

    logic              w_cmd_rdy;
    logic              w_wr;
    logic              w_load;
    logic              w_tacc;
    logic              w_tlast;
    logic              w_last_acc;
    logic [8:0]        w_blen;
    logic [CNT_W-1:0]  w_free;
    logic              w_unused;

    // Burst length for the next AR: bounded by what is left and by MAX_BURST.
`ifdef DMA_4K_SPLIT_EN
    logic [12:0] w_to4k;
    always_comb begin
        w_blen = 9'(MAX_BURST);
        if (r_rem < LEN_W'(MAX_BURST))
            w_blen = r_rem[8:0];
        // beats left before the next 4 KB page; never exceeds 4096/BYTES
        w_to4k = (13'h1000 - {1'b0, r_addr[11:0]}) >> SZ;
        if (w_to4k < {4'b0, w_blen})
            w_blen = w_to4k[8:0];
    end
`else
    always_comb begin
        w_blen = 9'(MAX_BURST);
        if (r_rem < LEN_W'(MAX_BURST))
            w_blen = r_rem[8:0];
    end
`endif

    // Only one burst is ever outstanding, so in ADDR the reservation is zero and plain free
    // space decides. The output register adds one slot of slack on top of FIFO_DEPTH.
    assign w_free     = CNT_W'(FIFO_DEPTH) - r_cnt;
    assign w_cmd_rdy  = r_rdy_en && (r_state == S_IDLE);
    assign w_wr       = (r_state == S_DATA) && bus.RVALID;
    assign w_load     = (r_cnt != '0) && (!r_tvalid || bus.TREADY);
    assign w_tacc     = r_tvalid && bus.TREADY;
    assign w_tlast    = r_tvalid && (r_send == r_len - LEN_W'(1));
    assign w_last_acc = w_tacc && w_tlast;
    assign w_unused   = ^{bus.RLAST, bus.RRESP[0]};

    always_ff @(posedge ACLK) begin
        if (w_wr)
            r_mem[r_wptr] <= bus.RDATA;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state   <= S_IDLE;
            r_rdy_en  <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
            r_rem     <= '0;
            r_blen    <= '0;
            r_beat    <= '0;
            r_send    <= '0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
            r_tvalid  <= 1'b0;
            r_tdata   <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_done   <= 1'b0;

            // FIFO bookkeeping; the output register refills whenever it is empty or being taken.
            if (w_wr)
                r_wptr <= r_wptr + PTR_W'(1);
            if (w_load) begin
                r_rptr   <= r_rptr + PTR_W'(1);
                r_tdata  <= r_mem[r_rptr];
                r_tvalid <= 1'b1;
            end else if (w_tacc) begin
                r_tvalid <= 1'b0;
            end
            r_cnt <= r_cnt + CNT_W'(w_wr) - CNT_W'(w_load);

            if (w_tacc)
                r_send <= r_send + LEN_W'(1);

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid && w_cmd_rdy) begin
                        r_addr  <= bus.cmd_addr & ~ADDR_W'(BYTES - 1);
                        r_len   <= bus.cmd_len;
                        r_rem   <= bus.cmd_len;
                        r_err   <= 1'b0;
                        r_send  <= '0;
                        r_state <= (bus.cmd_len == '0) ? S_DRAIN : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (!r_arvalid) begin
                        if (w_free >= CNT_W'(w_blen)) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_addr;
                            r_arlen   <= 8'(w_blen - 9'd1);
                            r_blen    <= w_blen;
                        end
                    end else if (bus.ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // The burst ends on our own beat count; RLAST is ignored.
                    if (bus.RVALID) begin
                        if (bus.RRESP[1])
                            r_err <= 1'b1;
                        r_beat <= r_beat + 9'd1;
                        if (r_beat == r_blen - 9'd1) begin
                            r_addr  <= r_addr + (ADDR_W'(r_blen) << SZ);
                            r_rem   <= r_rem - LEN_W'(r_blen);
                            r_state <= (r_rem == LEN_W'(r_blen)) ? S_DRAIN : S_ADDR;
                        end
                    end
                end
                default: begin // S_DRAIN
                    // Finish on the edge that takes the TLAST beat; the second term covers len == 0.
                    if (w_last_acc || (r_send == r_len && r_cnt == '0 && !r_tvalid)) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_ready = w_cmd_rdy;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.ARVALID   = r_arvalid;
    assign bus.ARADDR    = r_araddr;
    assign bus.ARLEN     = r_arlen;
    assign bus.ARSIZE    = 3'(SZ);
    assign bus.ARBURST   = 2'b01;
    assign bus.RREADY    = (r_state == S_DATA);
    assign bus.TVALID    = r_tvalid;
    assign bus.TDATA     = r_tdata;
    assign bus.TLAST     = w_tlast;
endmodule
